// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam logic [3:0]  AN_OFF     = 4'hF;

    // Phase within one digit slot: anodes dark, then one anode driven.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hexto7segment.sv
// Combinational hex nibble to seven-segment glyph, active-low {g,f,e,d,c,b,a}.
module hexto7segment (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Standard hex glyph table; lowercase forms for b and d.
    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode display scanner with per-slot anti-ghost blanking.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero glyphs
// on digits 3..1 (anode and decimal point still driven).
//
// Handshake: no valid/ready; value/dp_in are sampled only on the frame_start
// cycle (cnt==0, idx==0), so mid-frame changes never tear the display.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int               CNT_W     = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [1:0]       IDX_LAST  = 2'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      value_q;
    logic [3:0]       dp_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_out_q;
    logic             frame_start_q;

    scan_state_e      state;
    logic             frame_cycle;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;
    logic             lead_zero;

    // Slot phase, frame-boundary detect, counter advance and nibble select.
    always_comb begin
        state       = (cnt_q < CNT_BLANK) ? BLANK : DRIVE;
        frame_cycle = (cnt_q == '0) && (idx_q == 2'd0);
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
        end
        case (idx_q)
            2'd0:    nibble = value_q[3:0];
            2'd1:    nibble = value_q[7:4];
            2'd2:    nibble = value_q[11:8];
            default: nibble = value_q[15:12];
        endcase
    end

    // Leading-zero suppression: digit i blanks when every nibble from i upward is zero.
    always_comb begin
        lead_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1:    lead_zero = (value_q[15:4]  == 12'h000);
            2'd2:    lead_zero = (value_q[15:8]  == 8'h00);
            2'd3:    lead_zero = (value_q[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
`endif
    end

    hexto7segment u_dec (
        .hex_i (nibble),
        .seg_o (seg_dec)
    );

    // Scan FSM: counters, frame capture and registered pin drive in one place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            value_q       <= 16'h0000;
            dp_q          <= 4'h0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_out_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else if (!enable) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_out_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_cycle;
            if (frame_cycle) begin
                value_q <= value;
                dp_q    <= dp_in;
            end
            if (state == DRIVE) begin
                an_q     <= ~(4'b0001 << idx_q);
                seg_q    <= lead_zero ? SEG_BLANK : seg_dec;
                dp_out_q <= ~dp_q[idx_q];
            end else begin
                an_q     <= AN_OFF;
                seg_q    <= SEG_BLANK;
                dp_out_q <= 1'b1;
            end
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

    localparam int DC = 8;
    localparam int BC = 2;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GD = 7'b0100001;
    localparam logic [6:0] GX = 7'h7F;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int n_cmp;
    int n_err;
    bit an_chk_on;

    seg_scan_ctrl #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .value       (value),
        .dp_in       (dp_in),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Anode legality on every falling edge once outputs are defined.
    always @(negedge clk) begin
        if (an_chk_on) begin
            n_cmp++;
            assert ((an === 4'b1111) || (an === 4'b1110) || (an === 4'b1101) ||
                    (an === 4'b1011) || (an === 4'b0111))
            else begin
                n_err++;
                $error("FAIL an_onehot: observed %b expected 1111 or one-hot-low", an);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, ".an"},  16'(an),  16'h000F);
        chk({tag, ".seg"}, 16'(seg), 16'h007F);
        chk({tag, ".dp"},  16'(dp),  16'h0001);
        chk({tag, ".fs"},  16'(frame_start), 16'h0000);
    endtask

    // One full digit slot: BC blank cycles then DC-BC drive cycles.
    task automatic run_slot(input int d, input logic [6:0] eseg, input logic edp, input logic efs);
        logic [3:0] ean;
        logic [6:0] es;
        logic       ed;
        logic       ef;
        for (int c = 0; c < DC; c++) begin
            step();
            ean = (c < BC) ? 4'b1111 : ~(4'b0001 << d);
            es  = (c < BC) ? GX : eseg;
            ed  = (c < BC) ? 1'b1 : edp;
            ef  = (c == 0) ? efs : 1'b0;
            chk($sformatf("d%0d c%0d an", d, c),  16'(an),  16'(ean));
            chk($sformatf("d%0d c%0d seg", d, c), 16'(seg), 16'(es));
            chk($sformatf("d%0d c%0d dp", d, c),  16'(dp),  16'(ed));
            chk($sformatf("d%0d c%0d fs", d, c),  16'(frame_start), 16'(ef));
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        an_chk_on = 1'b0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        value     = 16'h1234;
        dp_in     = 4'h0;

        // Reset state (enable high during reset: reset wins)
        step();
        an_chk_on = 1'b1;
        step();
        chk_blank("reset");

        // Frame 1: 1234, digits 0..3 show 4,3,2,1
        rst_n = 1'b1;
        run_slot(0, G4, 1'b1, 1'b1);
        run_slot(1, G3, 1'b1, 1'b0);
        run_slot(2, G2, 1'b1, 1'b0);
        run_slot(3, G1, 1'b1, 1'b0);

        // Frame 2: value changes mid-frame, display holds 1234
        run_slot(0, G4, 1'b1, 1'b1);
        value = 16'hABCD;
        run_slot(1, G3, 1'b1, 1'b0);
        run_slot(2, G2, 1'b1, 1'b0);
        run_slot(3, G1, 1'b1, 1'b0);

        // Frame 3: new capture shows D,C,B,A
        run_slot(0, GD, 1'b1, 1'b1);
        run_slot(1, GC, 1'b1, 1'b0);
        run_slot(2, GB, 1'b1, 1'b0);
        run_slot(3, GA, 1'b1, 1'b0);

        // Frame 4: 0500 with decimal point on digit 2
        value = 16'h0500;
        dp_in = 4'b0100;
        run_slot(0, G0, 1'b1, 1'b1);
        run_slot(1, G0, 1'b1, 1'b0);
        run_slot(2, G5, 1'b0, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
        run_slot(3, GX, 1'b1, 1'b0);
`else
        run_slot(3, G0, 1'b1, 1'b0);
`endif

        // Frame 5: reset asserted so the cnt=5 edge of digit 2 samples it
        run_slot(0, G0, 1'b1, 1'b1);
        run_slot(1, G0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) step();
        chk("pre_rst.an", 16'(an), 16'h000B);
        rst_n = 1'b0;
        step();
        chk_blank("mid_rst");
        step();
        chk_blank("mid_rst_hold");
        rst_n = 1'b1;
        run_slot(0, G0, 1'b1, 1'b1);

        // Disable in the middle of digit 1 drive
        for (int c = 0; c < 4; c++) step();
        chk("pre_dis.an", 16'(an), 16'h000D);
        enable = 1'b0;
        value  = 16'h0009;
        dp_in  = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            step();
            chk_blank($sformatf("dis%0d", c));
        end

        // Re-enable: immediate capture, then a full frame of 0009
        enable = 1'b1;
        run_slot(0, G9, 1'b0, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        run_slot(1, GX, 1'b1, 1'b0);
        run_slot(2, GX, 1'b1, 1'b0);
        run_slot(3, GX, 1'b1, 1'b0);
`else
        run_slot(1, G0, 1'b1, 1'b0);
        run_slot(2, G0, 1'b1, 1'b0);
        run_slot(3, G0, 1'b1, 1'b0);
`endif
        run_slot(0, G9, 1'b0, 1'b1);

        an_chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
